// File: rtl/bus_xfer_seq_if.sv
// bus_xfer_seq_if: requester/bus-snoop side and select/strobe side of the bus transfer sequencer
interface bus_xfer_seq_if #(parameter int WIDTH = 32);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] BusMuxOut;
  logic             RZout;
  logic             RAout;
  logic             RBout;
  logic             RAin;
  logic             RBin;
  logic             Yin;
  logic             Zin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] xfer_data;
  modport master (
    output start, op, BusMuxOut,
    input  RZout, RAout, RBout, RAin, RBin, Yin, Zin, busy, done, xfer_data
  );
  modport slave (
    input  start, op, BusMuxOut,
    output RZout, RAout, RBout, RAin, RBin, Yin, Zin, busy, done, xfer_data
  );
endinterface

// File: rtl/bus_xfer_seq.sv
// bus_xfer_seq: drives one-hot bus selects and load strobes for one transfer/ALU micro-sequence per start
module bus_xfer_seq #(
  parameter int WIDTH = 32
) (
  input  logic           clock,
  input  logic           clear_n,
  bus_xfer_seq_if.slave  b
);
  typedef enum logic [2:0] {IDLE, T1, T2, T3, DONE} state_t;
  localparam logic [1:0] MOVE_AB = 2'b00;
  localparam logic [1:0] MOVE_BA = 2'b01;
  localparam logic [1:0] ALU     = 2'b10;
  localparam logic [1:0] LOAD_ZB = 2'b11;
  state_t           state;
  state_t           nxt;
  logic [1:0]       op_q;
  logic [1:0]       op_n;
  logic             t1;
  logic             cap;
  logic [WIDTH-1:0] xfer_q;
  // outputs are registered from the next state, so T1 decode must use the op being latched this edge
  always_comb begin
    op_n = (state == IDLE && b.start) ? b.op : op_q;
    nxt  = state == IDLE ? (b.start ? T1 : IDLE) :
           state == T1   ? (op_q == ALU ? T2 : DONE) :
           state == T2   ? T3 :
           state == T3   ? DONE : IDLE;
    t1   = nxt == T1;
    cap  = (state == T1 && op_q != ALU) || state == T3;
  end
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state   <= IDLE;
      op_q    <= MOVE_AB;
      xfer_q  <= '0;
      b.RZout <= 1'b0;
      b.RAout <= 1'b0;
      b.RBout <= 1'b0;
      b.RAin  <= 1'b0;
      b.RBin  <= 1'b0;
      b.Yin   <= 1'b0;
      b.Zin   <= 1'b0;
      b.busy  <= 1'b0;
      b.done  <= 1'b0;
    end else begin
      state   <= nxt;
      op_q    <= op_n;
      xfer_q  <= cap ? b.BusMuxOut : xfer_q;
      b.RZout <= (t1 && op_n == LOAD_ZB) || nxt == T3;
      b.RAout <= t1 && (op_n == MOVE_AB || op_n == ALU);
      b.RBout <= (t1 && op_n == MOVE_BA) || nxt == T2;
      b.RAin  <= (t1 && op_n == MOVE_BA) || nxt == T3;
      b.RBin  <= t1 && (op_n == MOVE_AB || op_n == LOAD_ZB);
      b.Yin   <= t1 && op_n == ALU;
      b.Zin   <= nxt == T2;
      b.busy  <= nxt != IDLE;
      b.done  <= nxt == DONE;
    end
  end
  assign b.xfer_data = xfer_q;
  // the bus multiplexer must never see two drivers
  a_onehot: assert property (@(posedge clock) disable iff (!clear_n) $onehot0({b.RZout, b.RAout, b.RBout}));
endmodule

// File: tb/tb_bus_xfer_seq.sv
// tb_bus_xfer_seq: directed and random scoreboard checks of the bus transfer sequencer
module tb_bus_xfer_seq;
  logic clk = 1'b0;
  logic clear_n;
  int   n_chk = 0;
  int   n_fail = 0;
  logic [31:0] sb[$];
  bus_xfer_seq_if #(.WIDTH(32)) bus ();
  bus_xfer_seq #(.WIDTH(32)) dut (.clock(clk), .clear_n(clear_n), .b(bus.slave));
  always #5 clk = ~clk;
  // {RZout,RAout,RBout,RAin,RBin,Yin,Zin,busy,done}
  logic [8:0] ovec;
  assign ovec = {bus.RZout, bus.RAout, bus.RBout, bus.RAin, bus.RBin, bus.Yin, bus.Zin, bus.busy, bus.done};
  localparam logic [8:0] V_IDLE  = 9'b000000000;
  localparam logic [8:0] V_AB    = 9'b010010010;
  localparam logic [8:0] V_BA    = 9'b001100010;
  localparam logic [8:0] V_ZB    = 9'b100010010;
  localparam logic [8:0] V_ALU1  = 9'b010001010;
  localparam logic [8:0] V_ALU2  = 9'b001000110;
  localparam logic [8:0] V_ALU3  = 9'b100100010;
  localparam logic [8:0] V_DONE  = 9'b000000011;
  function automatic logic [8:0] t1_vec(input logic [1:0] o);
    return o == 2'b00 ? V_AB : o == 2'b01 ? V_BA : o == 2'b10 ? V_ALU1 : V_ZB;
  endfunction
  task automatic chk_vec(input string name, input logic [8:0] exp);
    n_chk++;
    if (ovec !== exp) begin
      n_fail++;
      $display("FAIL %s: outputs=%b required=%b at %0t", name, ovec, exp, $time);
    end
  endtask
  task automatic chk_xfer(input string name);
    logic [31:0] e;
    n_chk++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL %s: scoreboard empty, xfer_data=%h", name, bus.xfer_data);
    end else begin
      e = sb.pop_front();
      if (bus.xfer_data !== e) begin
        n_fail++;
        $display("FAIL %s: xfer_data=%h required=%h", name, bus.xfer_data, e);
      end
    end
  endtask
  // first negedge is the IDLE cycle in which start is presented
  task automatic do_seq(input string name, input logic [1:0] o, input logic [31:0] d1, input logic [31:0] d2,
                        input logic [31:0] d3, input bit hold, input bit flip);
    @(negedge clk);
    chk_vec({name, "_idle"}, V_IDLE);
    bus.start = 1'b1;
    bus.op = o;
    bus.BusMuxOut = 32'h0;
    @(negedge clk);
    chk_vec({name, "_t1"}, t1_vec(o));
    if (!hold) bus.start = 1'b0;
    if (flip) bus.op = 2'b10;
    bus.BusMuxOut = d1;
    if (o != 2'b10) sb.push_back(d1);
    else begin
      @(negedge clk);
      chk_vec({name, "_t2"}, V_ALU2);
      bus.BusMuxOut = d2;
      @(negedge clk);
      chk_vec({name, "_t3"}, V_ALU3);
      bus.BusMuxOut = d3;
      sb.push_back(d3);
    end
    @(negedge clk);
    chk_vec({name, "_done"}, V_DONE);
    chk_xfer({name, "_xfer"});
    bus.BusMuxOut = 32'hFFFF_FFFF;
  endtask
  task automatic test_reset;
    clear_n = 1'b0;
    bus.start = 1'b1;
    bus.op = 2'b10;
    bus.BusMuxOut = 32'h1234_5678;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_vec("reset_outputs", V_IDLE);
    n_chk++;
    if (bus.xfer_data !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_xfer: xfer_data=%h required=0", bus.xfer_data);
    end
    bus.start = 1'b0;
    clear_n = 1'b1;
  endtask
  task automatic test_move_ab;
    do_seq("move_ab", 2'b00, 32'hDEAD_BEEF, 0, 0, 0, 0);
    do_seq("move_ba", 2'b01, 32'h0BAD_F00D, 0, 0, 0, 0);
  endtask
  task automatic test_alu;
    do_seq("alu", 2'b10, 32'd5, 32'd7, 32'd12, 0, 0);
  endtask
  task automatic test_back_to_back;
    do_seq("zb_hold1", 2'b11, 32'hA5A5_0001, 0, 0, 1, 0);
    do_seq("zb_hold2", 2'b11, 32'hA5A5_0002, 0, 0, 0, 0);
  endtask
  task automatic test_op_change;
    do_seq("op_change", 2'b00, 32'hCAFE_0042, 0, 0, 0, 1);
    bus.op = 2'b00;
  endtask
  task automatic test_reset_mid_alu;
    @(negedge clk);
    bus.start = 1'b1;
    bus.op = 2'b10;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    chk_vec("mid_alu_t2", V_ALU2);
    #2 clear_n = 1'b0;
    #1;
    chk_vec("mid_alu_async", V_IDLE);
    n_chk++;
    if (bus.xfer_data !== 32'h0) begin
      n_fail++;
      $display("FAIL mid_alu_xfer: xfer_data=%h required=0", bus.xfer_data);
    end
    repeat (3) begin
      @(negedge clk);
      chk_vec("mid_alu_held", V_IDLE);
    end
    clear_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk_vec("mid_alu_nodone", V_IDLE);
    end
  endtask
  task automatic test_random;
    int ms = 0;
    logic [1:0] mop = 2'b00;
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      n_chk++;
      if ($countones({bus.RZout, bus.RAout, bus.RBout}) > 1 || bus.busy !== (ms != 0) || bus.done !== (ms == 4)) begin
        n_fail++;
        $display("FAIL rand_onehot_busy: outputs=%b model_state=%0d cycle=%0d", ovec, ms, i);
      end
      if (ms == 4) chk_xfer("rand_xfer");
      bus.start = 1'($urandom_range(0, 1));
      bus.op = 2'($urandom_range(0, 3));
      bus.BusMuxOut = $urandom;
      if ((ms == 1 && mop != 2'b10) || ms == 3) sb.push_back(bus.BusMuxOut);
      case (ms)
        0: begin
          ms = bus.start ? 1 : 0;
          if (bus.start) mop = bus.op;
        end
        1: ms = mop == 2'b10 ? 2 : 4;
        2: ms = 3;
        3: ms = 4;
        default: ms = 0;
      endcase
    end
    bus.start = 1'b0;
    repeat (6) @(negedge clk);
    sb.delete();
  endtask
  initial begin
    bus.start = 1'b0;
    bus.op = 2'b00;
    bus.BusMuxOut = 32'h0;
    test_reset;
    test_move_ab;
    test_alu;
    test_back_to_back;
    test_op_change;
    test_reset_mid_alu;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
